// File: rtl/serial_pkg.sv
// Shared serial-link constants: FSM state encodings and default framing parameters.
package serial_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned DATA_BITS_DEF    = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with configurable reset value.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic meta;

  // Resolve metastability over two stages; both flops reset to the idle level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= RESET_VALUE;
      Q    <= RESET_VALUE;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx_deframer.sv
// UART-style receive deframer: start-bit glitch rejection, mid-bit sampling,
// LSB-first assembly and one-cycle valid / framing-error strobes.
module serial_rx_deframer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 RX_FRAME_ERR,
  output logic                 RX_BUSY
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev;
  logic [1:0]           warm;
  logic                 fall;

  logic [1:0]           state,   state_n;
  logic [CNT_W-1:0]     cnt,     cnt_n;
  logic [IDX_W-1:0]     idx,     idx_n;
  logic [DATA_BITS-1:0] shreg,   shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n;
  logic                 ferr_n;
  logic                 busy_n;

  sync_2ff #(.RESET_VALUE(1'b1)) u_rx_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (RX),
    .Q   (rx_s)
  );

  // The synchroniser and rx_prev hold stale reset values for a few cycles after
  // reset; edges are ignored until they carry real line samples, so a line held
  // low through reset never looks like a start bit.
  assign fall = rx_prev & ~rx_s & (warm == 2'd3);

  // Next-state, counters, shift register and strobe decisions.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = RX_DATA;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (fall) state_n = ST_START;
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          idx_n   = idx + IDX_W'(1);
          if (idx == IDX_LAST) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
          if (rx_s) begin
            data_n  = shreg;
            valid_n = 1'b1;
          end else begin
            ferr_n  = 1'b1;
          end
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      rx_prev      <= 1'b1;
      warm         <= 2'd0;
      RX_DATA      <= '0;
      RX_VALID     <= 1'b0;
      RX_FRAME_ERR <= 1'b0;
      RX_BUSY      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      shreg        <= shreg_n;
      rx_prev      <= rx_s;
      if (warm != 2'd3) warm <= warm + 2'd1;
      RX_DATA      <= data_n;
      RX_VALID     <= valid_n;
      RX_FRAME_ERR <= ferr_n;
      RX_BUSY      <= busy_n;
    end
  end

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Directed bench for serial_rx_deframer (CLKS_PER_BIT=16, DATA_BITS=8).
module tb_serial_rx_deframer;

  localparam int CPB       = 16;
  localparam int FRAME_LAT = 155;  // negedge of RX drive -> cycle RX_VALID is visible
  localparam int FRAME_LEN = 160;  // 10 bits x 16 clocks

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int viol = 0;
  int busy_cnt = 0;
  logic prev_strobe = 1'b0;

  int         v_cyc_q[$];
  logic [7:0] v_dat_q[$];
  int         e_cyc_q[$];

  vec_t vecs[4];

  serial_rx_deframer #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .CLK          (clk),
    .RST          (rst),
    .RX           (rx),
    .RX_DATA      (rx_data),
    .RX_VALID     (rx_valid),
    .RX_FRAME_ERR (rx_frame_err),
    .RX_BUSY      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record strobes and watch for overlapping or back-to-back strobes.
  always @(negedge clk) begin
    if (rst) begin
      prev_strobe <= 1'b0;
    end else begin
      if (rx_valid) begin
        v_cyc_q.push_back(cyc);
        v_dat_q.push_back(rx_data);
      end
      if (rx_frame_err) e_cyc_q.push_back(cyc);
      if (rx_busy) busy_cnt <= busy_cnt + 1;
      if ((rx_valid && rx_frame_err) || ((rx_valid || rx_frame_err) && prev_strobe))
        viol <= viol + 1;
      prev_strobe <= rx_valid | rx_frame_err;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_events();
    v_cyc_q.delete();
    v_dat_q.delete();
    e_cyc_q.delete();
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Called on a negedge; returns the cycle at which the start bit was driven.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  initial begin
    int t0;
    int t1;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'hC3, 1'b1, 1, 0, 8'hC3};
    vecs[3] = '{8'h17, 1'b1, 1, 0, 8'h17};

    // Reset with the line held low.
    rx  = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_frame_err", int'(rx_frame_err), 0);
    check("reset_rx_busy", int'(rx_busy), 0);
    rst = 1'b0;

    // Line stays low out of reset: never a frame.
    repeat (200) @(negedge clk);
    check("low_from_reset_busy_cycles", busy_cnt, 0);
    check("low_from_reset_valid_count", v_cyc_q.size(), 0);
    check("low_from_reset_ferr_count", e_cyc_q.size(), 0);

    rx = 1'b1;
    repeat (20) @(negedge clk);
    clear_events();
    send_frame(8'h81, 1'b1, t0);
    repeat (20) @(negedge clk);
    check("after_low_valid_count", v_cyc_q.size(), 1);
    check("after_low_rx_data", int'(rx_data), 8'h81);
    if (v_cyc_q.size() > 0) check("after_low_valid_cycle", v_cyc_q[0] - t0, FRAME_LAT);

    // Table-driven single frames.
    for (int k = 0; k < 4; k++) begin
      clear_events();
      send_frame(vecs[k].data, vecs[k].stop, t0);
      if (!vecs[k].stop) repeat (30) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check($sformatf("vec%0d_valid_count", k), v_cyc_q.size(), vecs[k].exp_valid);
      check($sformatf("vec%0d_ferr_count", k), e_cyc_q.size(), vecs[k].exp_ferr);
      check($sformatf("vec%0d_rx_data", k), int'(rx_data), int'(vecs[k].exp_data));
      check($sformatf("vec%0d_busy_idle", k), int'(rx_busy), 0);
      if (vecs[k].exp_valid == 1 && v_cyc_q.size() > 0)
        check($sformatf("vec%0d_valid_cycle", k), v_cyc_q[0] - t0, FRAME_LAT);
      if (vecs[k].exp_ferr == 1 && e_cyc_q.size() > 0)
        check($sformatf("vec%0d_ferr_cycle", k), e_cyc_q[0] - t0, FRAME_LAT);
    end

    // Start-bit glitch: low for 4 cycles.
    clear_events();
    t0 = cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("glitch_busy_before_drop", int'(rx_busy), 1);
    @(negedge clk);
    check("glitch_busy_dropped", int'(rx_busy), 0);
    repeat (30) @(negedge clk);
    check("glitch_valid_count", v_cyc_q.size(), 0);
    check("glitch_ferr_count", e_cyc_q.size(), 0);
    check("glitch_rx_data", int'(rx_data), 8'h17);

    // Back-to-back frames, zero idle.
    clear_events();
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    repeat (20) @(negedge clk);
    check("b2b_valid_count", v_cyc_q.size(), 2);
    check("b2b_ferr_count", e_cyc_q.size(), 0);
    if (v_cyc_q.size() == 2) begin
      check("b2b_first_data", int'(v_dat_q[0]), 8'h00);
      check("b2b_second_data", int'(v_dat_q[1]), 8'hFF);
      check("b2b_spacing", v_cyc_q[1] - v_cyc_q[0], FRAME_LEN);
      check("b2b_first_cycle", v_cyc_q[0] - t0, FRAME_LAT);
    end

    // Reset during data bit 3 of a 0x5A frame.
    repeat (20) @(negedge clk);
    clear_events();
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("midframe_busy", int'(rx_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rx_data", int'(rx_data), 0);
    check("midrst_rx_valid", int'(rx_valid), 0);
    check("midrst_rx_frame_err", int'(rx_frame_err), 0);
    check("midrst_rx_busy", int'(rx_busy), 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("midrst_discard_valid", v_cyc_q.size(), 0);
    check("midrst_discard_ferr", e_cyc_q.size(), 0);
    clear_events();
    send_frame(8'h5A, 1'b1, t0);
    repeat (20) @(negedge clk);
    check("post_rst_valid_count", v_cyc_q.size(), 1);
    check("post_rst_rx_data", int'(rx_data), 8'h5A);
    if (v_cyc_q.size() > 0) check("post_rst_valid_cycle", v_cyc_q[0] - t0, FRAME_LAT);

    check("strobe_exclusive_and_single", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx_deframer.md
# serial_rx_deframer

Receive-side counterpart of the serial TX line conditioner: recovers bytes from an asynchronous UART-style serial line (idle high, one start bit, LSB-first data, one stop bit). Synchronises the line into the CLK domain, rejects start-bit glitches, samples each bit at mid-period, and presents each received word with a one-cycle valid strobe. Sits between the board-level serial input pin and the downstream byte consumer.

## Interface
- CLKS_PER_BIT, 16, CLK cycles per serial bit; even, ≥ 4
- DATA_BITS, 8, data bits per frame; 5..9
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  reset, synchronous, active-high
- RX  input  1  asynchronous serial line, idle high
- RX_DATA  output  DATA_BITS  last correctly framed word; reset 0
- RX_VALID  output  1  one-cycle strobe, RX_DATA newly updated; reset 0
- RX_FRAME_ERR  output  1  one-cycle strobe, stop bit sampled low; reset 0
- RX_BUSY  output  1  high whenever FSM not in IDLE; reset 0

## Operation
- RX passes through a 2-flop synchroniser (reset value 1) → rx_s; a third flop holds rx_s of the previous cycle for falling-edge detect.
- Bit counter: $clog2(CLKS_PER_BIT) bits; bit index: $clog2(DATA_BITS+1) bits; shift register: DATA_BITS bits, filled LSB first (shift right, new bit into MSB).
- FSM states: IDLE, START, DATA, STOP.
- IDLE: counter cleared. Falling edge on rx_s (prev 1, now 0) → START. Line held low from reset (no edge) never starts a frame.
- START: count to CLKS_PER_BIT/2−1, then sample rx_s. If 0 → DATA, counter and bit index cleared. If 1 → IDLE (glitch), no strobe.
- DATA: count to CLKS_PER_BIT−1, sample rx_s into shift register, increment bit index, clear counter. After the DATA_BITS-th sample → STOP.
- STOP: count to CLKS_PER_BIT−1, sample rx_s. If 1 → RX_DATA ← shift register, RX_VALID=1 next cycle. If 0 → RX_FRAME_ERR=1 next cycle, RX_DATA unchanged. Both → IDLE.
- RX_VALID and RX_FRAME_ERR are mutually exclusive and never high two consecutive cycles.
- RST in any state: FSM → IDLE, counters/shift register/RX_DATA → 0, strobes → 0, synchroniser flops → 1, on the next edge. A partial frame is discarded. Frame reception resumes only on a fresh falling edge seen after reset is released.
- Framing error followed by a line that stays low: no new frame until rx_s returns high and falls again.

## Timing
- Let E be the first cycle where rx_s=0 and previous rx_s=1 (E is 2–3 CLKs after the RX pin falls, due to the synchroniser).
- Start sample: E + CLKS_PER_BIT/2.
- Data bit i (i = 0..DATA_BITS−1) sampled at E + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
- Stop sample: S = E + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT; RX_VALID/RX_FRAME_ERR high in cycle S+1 only.
- RX_BUSY rises in E+1 and falls in S+1. IDLE is re-entered at S+1, so a start edge arriving during the second half of the stop bit is detected. Back-to-back frames with zero idle time are supported.
- Tolerates ±(CLKS_PER_BIT/2 − 1) cycles of cumulative drift per frame.

## Structure
- Shared package/include `serial_pkg`: FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3) and default CLKS_PER_BIT/DATA_BITS constants, also used by the TX-side blocks.
- One sub-module: `sync_2ff` (parameterised reset value, CLK/RST/D/Q), instantiated for RX. Everything else stays in serial_rx_deframer.

## Test plan
- CLKS_PER_BIT=16, DATA_BITS=8. Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), stop=1 → RX_DATA=0xA5, RX_VALID high exactly one cycle at S+1, RX_FRAME_ERR never high.
- RX low for 4 cycles, then high → no strobe; RX_BUSY returns to 0 at E+9; RX_DATA unchanged.
- Frame 0x3C with stop bit driven 0 → RX_FRAME_ERR one cycle, RX_VALID 0, RX_DATA keeps previous value 0xA5.
- Frames 0x00 then 0xFF with zero idle between them → two RX_VALID strobes exactly 10·16 cycles apart, with data 0x00 then 0xFF.
- RST asserted for one cycle during data bit 3 → all outputs 0 on the next cycle. Line then idles high, then a frame 0x5A → RX_DATA=0x5A, single RX_VALID.
- RX held low out of reset for 200 cycles, then high, then frame 0x81 → no strobe during the low period; then RX_DATA=0x81 with RX_VALID.
